// File: rtl/eth_tx_frame_prep.sv
// Frame-preparation stage for the 100M MII transmit MAC: buffers one frame's payload,
// computes the 802.3 FCS over header + padded payload, then feeds nibbles to the MAC.
module eth_tx_frame_prep #(
  parameter int MAX_BYTES  = 1023,
  parameter int MIN_BYTES  = 46,
  parameter int GAP_CYCLES = 40
) (
  input  logic        mii_tx_clk,
  input  logic        rst_n,
  input  logic [47:0] hdr_des_mac,
  input  logic [47:0] hdr_src_mac,
  input  logic [15:0] hdr_len_type,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        tx_go,
  output logic [10:0] data_len,
  output logic [47:0] des_mac,
  output logic [47:0] src_mac,
  output logic [15:0] len_type,
  output logic [31:0] crc_res,
  input  logic        fifo_rq,
  output logic [3:0]  fifo_da,
  output logic        err_oversize,
  output logic        busy
);

  localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [9:0]    MAX_C    = 10'(MAX_BYTES);
  localparam logic [9:0]    MIN_C    = 10'(MIN_BYTES);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PAY, S_DROP, S_PAD, S_FIN, S_SEND, S_GAP
  } state_t;

  state_t        r_state;
  logic [31:0]   r_crc;
  logic [9:0]    r_cnt;
  logic [9:0]    r_rd_ptr;
  logic          r_rd_hi;
  logic [10:0]   r_nib_left;
  logic [3:0]    r_hdr_idx;
  logic [GW-1:0] r_gap;
  logic [7:0]    r_ram [0:1023];

  logic [111:0]  w_hdr_vec;
  logic [7:0]    w_hdr_byte;
  logic [7:0]    w_crc_din;
  logic [31:0]   w_crc_next;
  logic [9:0]    w_cnt_inc;
  logic          w_ram_we;
  logic [7:0]    w_ram_wd;
  logic [7:0]    w_ram_rd;

  // Reflected CRC-32 (poly 0x04C11DB7 reversed), one byte per call
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h000000, d};
    for (int unsigned i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Header bytes in transmit order: dst[0..5], src[0..5], len_type hi, len_type lo
  assign w_hdr_vec  = {len_type[7:0], len_type[15:8], src_mac, des_mac};
  assign w_hdr_byte = w_hdr_vec[{r_hdr_idx, 3'b000} +: 8];
  assign w_cnt_inc  = r_cnt + 10'd1;

  always_comb begin
    w_crc_din = 8'h00;
    if (r_state == S_HDR)      w_crc_din = w_hdr_byte;
    else if (r_state == S_PAY) w_crc_din = in_data;
  end

  assign w_crc_next = crc_byte(r_crc, w_crc_din);

  assign in_ready = (r_state == S_PAY) || (r_state == S_DROP);
  assign busy     = (r_state != S_IDLE);

  // The byte counter doubles as the RAM write pointer
  assign w_ram_we = ((r_state == S_PAY) && in_valid) || (r_state == S_PAD);
  assign w_ram_wd = (r_state == S_PAY) ? in_data : 8'h00;

  always_ff @(posedge mii_tx_clk) begin
    if (w_ram_we) r_ram[r_cnt] <= w_ram_wd;
  end

  assign w_ram_rd = r_ram[r_rd_ptr];
  assign fifo_da  = (r_state == S_SEND) ? (r_rd_hi ? w_ram_rd[7:4] : w_ram_rd[3:0]) : 4'h0;

  always_ff @(posedge mii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_crc        <= '0;
      r_cnt        <= '0;
      r_rd_ptr     <= '0;
      r_rd_hi      <= 1'b0;
      r_nib_left   <= '0;
      r_hdr_idx    <= '0;
      r_gap        <= '0;
      tx_go        <= 1'b0;
      err_oversize <= 1'b0;
      data_len     <= '0;
      crc_res      <= '0;
      des_mac      <= '0;
      src_mac      <= '0;
      len_type     <= '0;
    end else begin
      tx_go        <= 1'b0;
      err_oversize <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            des_mac   <= hdr_des_mac;
            src_mac   <= hdr_src_mac;
            len_type  <= hdr_len_type;
            r_crc     <= '1;
            r_cnt     <= '0;
            r_rd_ptr  <= '0;
            r_rd_hi   <= 1'b0;
            r_hdr_idx <= '0;
            r_state   <= S_HDR;
          end
        end
        S_HDR: begin
          r_crc     <= w_crc_next;
          r_hdr_idx <= r_hdr_idx + 4'd1;
          if (r_hdr_idx == 4'd13) r_state <= S_PAY;
        end
        S_PAY: begin
          if (in_valid) begin
            r_crc <= w_crc_next;
            r_cnt <= w_cnt_inc;
            if (in_last) begin
              r_state <= (w_cnt_inc < MIN_C) ? S_PAD : S_FIN;
            end else if (w_cnt_inc == MAX_C) begin
              err_oversize <= 1'b1;
              r_state      <= S_DROP;
            end
          end
        end
        S_DROP: begin
          if (in_valid && in_last) r_state <= S_FIN;
        end
        S_PAD: begin
          r_crc <= w_crc_next;
          r_cnt <= w_cnt_inc;
          if (w_cnt_inc >= MIN_C) r_state <= S_FIN;
        end
        S_FIN: begin
          crc_res    <= {~r_crc[7:0], ~r_crc[15:8], ~r_crc[23:16], ~r_crc[31:24]};
          data_len   <= {r_cnt, 1'b0};
          r_nib_left <= {r_cnt, 1'b0};
          r_rd_ptr   <= '0;
          r_rd_hi    <= 1'b0;
          tx_go      <= 1'b1;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          if (fifo_rq) begin
            r_rd_hi    <= ~r_rd_hi;
            r_nib_left <= r_nib_left - 11'd1;
            if (r_rd_hi) r_rd_ptr <= r_rd_ptr + 10'd1;
            if (r_nib_left == 11'd1) begin
              r_gap   <= '0;
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) r_state <= S_IDLE;
          else                   r_gap   <= r_gap + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_prep.sv
// Bench for eth_tx_frame_prep: table of frame scenarios, CRC model, nibble scoreboard.
module tb_eth_tx_frame_prep;

  localparam int MAXB = 1023;
  localparam int MINB = 46;
  localparam int GAPC = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] hdr_des_mac = '0;
  logic [47:0] hdr_src_mac = '0;
  logic [15:0] hdr_len_type = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        tx_go;
  logic [10:0] data_len;
  logic [47:0] des_mac, src_mac;
  logic [15:0] len_type;
  logic [31:0] crc_res;
  logic        fifo_rq = 1'b0;
  logic [3:0]  fifo_da;
  logic        err_oversize;
  logic        busy;

  always #5 clk = ~clk;

  eth_tx_frame_prep #(.MAX_BYTES(MAXB), .MIN_BYTES(MINB), .GAP_CYCLES(GAPC)) dut (
    .mii_tx_clk(clk), .rst_n(rst_n),
    .hdr_des_mac(hdr_des_mac), .hdr_src_mac(hdr_src_mac), .hdr_len_type(hdr_len_type),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .tx_go(tx_go), .data_len(data_len), .des_mac(des_mac), .src_mac(src_mac),
    .len_type(len_type), .crc_res(crc_res), .fifo_rq(fifo_rq), .fifo_da(fifo_da),
    .err_oversize(err_oversize), .busy(busy)
  );

  typedef struct {
    int n;        // payload bytes offered
    int mode;     // 0 incrementing, 1 random, 2 constant 0xAB
    bit gaps;     // random in_valid gaps
    bit early;    // raise in_valid while previous frame is still in GAP
    bit wait_gap; // wait out and measure GAP after the frame
    int rst_at;   // pulse reset after this many accepted bytes (-1 never)
    int exp_len;  // expected data_len
  } vec_t;

  vec_t        vecs[$];
  logic [3:0]  exp_q[$];
  logic [47:0] prev_des = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bit-serial reflected CRC-32
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic run_frame(input vec_t v);
    logic [7:0]  pay[$];
    logic [7:0]  mb[$];
    logic [47:0] d, s;
    logic [15:0] lt;
    logic [31:0] c, exp_crc;
    int plen, pad, idx, guard, lat, txc, errs, err_idx, gapn;
    bit vld, acc, rq;

    d  = {16'($urandom()), $urandom()};
    s  = {16'($urandom()), $urandom()};
    lt = 16'($urandom());
    for (int i = 0; i < v.n; i++) begin
      case (v.mode)
        0:       pay.push_back(8'(i));
        1:       pay.push_back(8'($urandom()));
        default: pay.push_back(8'hAB);
      endcase
    end
    plen = (v.n > MAXB) ? MAXB : v.n;
    pad  = (plen < MINB) ? (MINB - plen) : 0;
    for (int k = 0; k < 6; k++) mb.push_back(d[8*k +: 8]);
    for (int k = 0; k < 6; k++) mb.push_back(s[8*k +: 8]);
    mb.push_back(lt[15:8]);
    mb.push_back(lt[7:0]);
    for (int i = 0; i < plen; i++) mb.push_back(pay[i]);
    for (int i = 0; i < pad; i++) mb.push_back(8'h00);
    c = '1;
    foreach (mb[i]) c = crc_upd(c, mb[i]);
    exp_crc = {~c[7:0], ~c[15:8], ~c[23:16], ~c[31:24]};
    exp_q.delete();
    for (int i = 14; i < mb.size(); i++) begin
      exp_q.push_back(mb[i][3:0]);
      exp_q.push_back(mb[i][7:4]);
    end

    if (!v.early) begin
      guard = 0;
      while (busy && guard < 2000) begin @(posedge clk); #1; guard++; end
      check("idle_wait", 64'(busy), 64'(0));
    end
    hdr_des_mac  = d;
    hdr_src_mac  = s;
    hdr_len_type = lt;
    in_valid     = 1'b1;
    in_data      = pay[0];
    in_last      = (v.n == 1);
    if (v.early) begin
      guard = 0;
      while (busy && guard < 2000) begin
        check("rdy_in_gap", 64'(in_ready), 64'(0));
        check("hdr_hold", 64'(des_mac), 64'(prev_des));
        @(posedge clk); #1; guard++;
      end
    end

    idx = 0; guard = 0; errs = 0; err_idx = -1;
    while (idx < v.n && guard < 20000) begin
      vld      = v.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_valid = vld;
      in_data  = pay[idx];
      in_last  = (idx == v.n - 1);
      if (v.rst_at >= 0 && idx == v.rst_at) begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        #2;
        check("rst_mid_outs", 64'(|{in_ready, tx_go, data_len, crc_res, des_mac, src_mac,
                                    len_type, fifo_da, err_oversize, busy}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        txc = 0;
        repeat (30) begin @(posedge clk); #1; if (tx_go) txc++; end
        check("no_tx_after_rst", 64'(txc), 64'(0));
        check("idle_after_rst", 64'(busy), 64'(0));
        return;
      end
      acc = vld && in_ready;
      @(posedge clk); #1; guard++;
      if (acc) idx++;
      if (err_oversize) begin errs++; err_idx = idx; end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    lat = 0;
    while (!tx_go && lat < 3000) begin
      @(posedge clk); #1; lat++;
      if (err_oversize) begin errs++; err_idx = idx; end
    end
    check("tx_go_latency", 64'(lat), 64'(pad + 1));
    if (v.n > MAXB) begin
      check("oversize_cnt", 64'(errs), 64'(1));
      check("oversize_at", 64'(err_idx), 64'(MAXB));
    end else begin
      check("no_oversize", 64'(errs), 64'(0));
    end

    if (tx_go) begin
      check("data_len", 64'(data_len), 64'(v.exp_len));
      check("crc_res", 64'(crc_res), 64'(exp_crc));
      check("des_mac", 64'(des_mac), 64'(d));
      check("src_mac", 64'(src_mac), 64'(s));
      check("len_type", 64'(len_type), 64'(lt));
      check("rdy_send", 64'(in_ready), 64'(0));
      txc = 0; guard = 0;
      while (exp_q.size() > 0 && guard < 20000) begin
        if (tx_go) txc++;
        rq      = ($urandom_range(0, 3) != 0);
        fifo_rq = rq;
        check("fifo_da", 64'(fifo_da), 64'(exp_q[0]));
        if (rq) void'(exp_q.pop_front());
        @(posedge clk); #1; guard++;
      end
      fifo_rq = 1'b0;
      check("nibbles_left", 64'(exp_q.size()), 64'(0));
      check("tx_go_count", 64'(txc), 64'(1));
    end
    exp_q.delete();

    // A pop on the empty FIFO must be ignored
    fifo_rq = 1'b1;
    @(posedge clk); #1;
    fifo_rq = 1'b0;
    check("fifo_empty", 64'(fifo_da), 64'(0));
    check("rdy_gap", 64'(in_ready), 64'(0));

    c = '1;
    foreach (mb[i]) c = crc_upd(c, mb[i]);
    c = crc_upd(c, crc_res[31:24]);
    c = crc_upd(c, crc_res[23:16]);
    c = crc_upd(c, crc_res[15:8]);
    c = crc_upd(c, crc_res[7:0]);
    check("crc_residue", 64'(c), 64'(32'hDEBB20E3));
    prev_des = d;

    if (v.wait_gap) begin
      // One GAP cycle already elapsed on the empty-pop edge above
      gapn = 0;
      while (busy && gapn < 2000) begin gapn++; @(posedge clk); #1; end
      check("gap_len", 64'(gapn), 64'(GAPC - 1));
      check("len_hold", 64'(data_len), 64'(v.exp_len));
      check("crc_hold", 64'(crc_res), 64'(exp_crc));
    end
  endtask

  initial begin
    vecs.push_back('{n:60,   mode:0, gaps:1'b0, early:1'b0, wait_gap:1'b1, rst_at:-1, exp_len:120});
    vecs.push_back('{n:1,    mode:2, gaps:1'b0, early:1'b0, wait_gap:1'b1, rst_at:-1, exp_len:92});
    vecs.push_back('{n:46,   mode:1, gaps:1'b1, early:1'b0, wait_gap:1'b1, rst_at:-1, exp_len:92});
    vecs.push_back('{n:47,   mode:1, gaps:1'b0, early:1'b0, wait_gap:1'b1, rst_at:-1, exp_len:94});
    vecs.push_back('{n:45,   mode:1, gaps:1'b1, early:1'b0, wait_gap:1'b1, rst_at:-1, exp_len:92});
    vecs.push_back('{n:1100, mode:0, gaps:1'b0, early:1'b0, wait_gap:1'b0, rst_at:-1, exp_len:2046});
    vecs.push_back('{n:50,   mode:1, gaps:1'b0, early:1'b1, wait_gap:1'b1, rst_at:-1, exp_len:100});
    vecs.push_back('{n:1023, mode:1, gaps:1'b1, early:1'b0, wait_gap:1'b1, rst_at:-1, exp_len:2046});
    vecs.push_back('{n:30,   mode:1, gaps:1'b0, early:1'b0, wait_gap:1'b1, rst_at:20, exp_len:0});
    vecs.push_back('{n:46,   mode:1, gaps:1'b0, early:1'b0, wait_gap:1'b1, rst_at:-1, exp_len:92});
    vecs.push_back('{n:64,   mode:1, gaps:1'b1, early:1'b0, wait_gap:1'b1, rst_at:-1, exp_len:128});
    vecs.push_back('{n:200,  mode:1, gaps:1'b1, early:1'b0, wait_gap:1'b1, rst_at:-1, exp_len:400});
    vecs.push_back('{n:13,   mode:1, gaps:1'b0, early:1'b0, wait_gap:1'b1, rst_at:-1, exp_len:92});

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_tx_go", 64'(tx_go), 64'(0));
    check("rst_data_len", 64'(data_len), 64'(0));
    check("rst_crc_res", 64'(crc_res), 64'(0));
    check("rst_macs", 64'(|{des_mac, src_mac, len_type}), 64'(0));
    check("rst_fifo_da", 64'(fifo_da), 64'(0));
    check("rst_err", 64'(err_oversize), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_frame(vecs[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
